// File: rtl/pwm_capture_if.sv
// Servo PWM capture bus: the raw PWM line in and the decoded measurement out.
interface pwm_capture_if;
    logic               pwm_in;
    logic        [31:0] pulse_width;
    logic signed [15:0] data_out;
    logic               data_valid;
    logic               range_err;
    logic               signal_lost;

    modport master (
        output pwm_in,
        input  pulse_width, data_out, data_valid, range_err, signal_lost
    );

    modport slave (
        input  pwm_in,
        output pulse_width, data_out, data_valid, range_err, signal_lost
    );
endinterface

// File: rtl/pwm_capture.sv
// Servo PWM pulse-width capture with linear decode; result strobes 26 cycles after the synchronized fall.
// Define PWM_CAPTURE_GLITCH_FILTER_EN for an 8-sample glitch filter (result latency becomes 34).
module pwm_capture #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int PWM_FREQ  = 50,
    parameter int PULSE_MIN = 25_000,
    parameter int PULSE_MAX = 150_000,
    parameter int ACCEL_MAX = 130
) (
    input  logic         clk,
    input  logic         rst,
    pwm_capture_if.slave bus
);
    localparam logic [31:0] PERIOD  = 32'(CLK_FREQ / PWM_FREQ);
    localparam logic [31:0] TO_MAX  = 32'(2 * (CLK_FREQ / PWM_FREQ));
    localparam logic [31:0] P_MIN   = 32'(PULSE_MIN);
    localparam logic [31:0] P_MAX   = 32'(PULSE_MAX);
    localparam logic [31:0] A_MAX   = 32'(ACCEL_MAX);
    localparam logic [24:0] DIVISOR = 25'(PULSE_MAX - PULSE_MIN);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam logic [3:0]  SETTLE  = 4'd10;
`else
    localparam logic [3:0]  SETTLE  = 4'd2;
`endif

    typedef enum logic [1:0] {WAIT_LOW, IDLE, HIGH, DIV} state_t;
    state_t state_q, state_d;

    logic        sync1, sync2, line, line_q, rise, settled;
    logic [3:0]  settle_cnt;
    logic [31:0] high_cnt, width_q, to_cnt, clamped, num;
    logic [23:0] rem, quo, rem_nx, quo_nx;
    logic [24:0] rem_sh;
    logic [4:0]  div_cnt;
    logic        held, err_q, div_done, abort, ge;

    // Reset zeroes the synchronizer, so its output is not trusted until real samples have flushed through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            line_q     <= 1'b0;
            settle_cnt <= 4'd0;
        end else begin
            sync1  <= bus.pwm_in;
            sync2  <= sync1;
            line_q <= line;
            if (!settled)
                settle_cnt <= settle_cnt + 4'd1;
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    logic       filt;
    logic [2:0] filt_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt     <= 1'b0;
            filt_cnt <= 3'd0;
        end else if (sync2 == filt) begin
            filt_cnt <= 3'd0;
        end else if (filt_cnt == 3'd7) begin
            filt     <= sync2;
            filt_cnt <= 3'd0;
        end else begin
            filt_cnt <= filt_cnt + 3'd1;
        end
    end

    assign line = filt;
`else
    assign line = sync2;
`endif

    assign rise    = line & ~line_q;
    assign settled = (settle_cnt == SETTLE);

    always_comb begin
        state_d  = state_q;
        abort    = 1'b0;
        div_done = 1'b0;
        // Clamping before the divide makes out-of-range pulses saturate to 0 / ACCEL_MAX exactly.
        clamped  = width_q;
        if (width_q < P_MIN)
            clamped = P_MIN;
        else if (width_q > P_MAX)
            clamped = P_MAX;
        num    = (clamped - P_MIN) * A_MAX;
        rem_sh = {rem, quo[23]};
        ge     = (rem_sh >= DIVISOR);
        rem_nx = ge ? 24'(rem_sh - DIVISOR) : rem_sh[23:0];
        quo_nx = {quo[22:0], ge};
        case (state_q)
            WAIT_LOW: if (settled && !line) state_d = IDLE;
            IDLE:     if (rise) state_d = HIGH;
            HIGH: begin
                if (high_cnt >= PERIOD) begin
                    abort   = 1'b1;
                    state_d = WAIT_LOW;
                end else if (!line) begin
                    state_d = DIV;
                end
            end
            DIV: begin
                if (div_cnt == 5'd24) begin
                    div_done = 1'b1;
                    state_d  = held ? HIGH : IDLE;
                end
            end
            default: state_d = WAIT_LOW;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= WAIT_LOW;
            high_cnt        <= 32'd0;
            width_q         <= 32'd0;
            to_cnt          <= 32'd0;
            rem             <= 24'd0;
            quo             <= 24'd0;
            div_cnt         <= 5'd0;
            held            <= 1'b0;
            err_q           <= 1'b0;
            bus.pulse_width <= 32'd0;
            bus.data_out    <= 16'sd0;
            bus.data_valid  <= 1'b0;
            bus.range_err   <= 1'b0;
            bus.signal_lost <= 1'b0;
        end else begin
            state_q        <= state_d;
            bus.data_valid <= div_done;
            case (state_q)
                IDLE: if (rise) high_cnt <= 32'd1;
                HIGH: begin
                    if (abort) begin
                        bus.range_err <= 1'b1;
                    end else if (line) begin
                        high_cnt <= high_cnt + 32'd1;
                    end else begin
                        width_q <= high_cnt;
                        div_cnt <= 5'd0;
                        held    <= 1'b0;
                    end
                end
                DIV: begin
                    // Step 0 loads the dividend; steps 1..24 each retire one quotient bit.
                    if (div_cnt == 5'd0) begin
                        quo   <= 24'(num);
                        rem   <= 24'd0;
                        err_q <= (width_q < P_MIN) || (width_q > P_MAX);
                    end else begin
                        rem <= rem_nx;
                        quo <= quo_nx;
                    end
                    div_cnt <= div_cnt + 5'd1;
                    if (div_done) begin
                        bus.pulse_width <= width_q;
                        bus.data_out    <= 16'(quo_nx);
                        bus.range_err   <= err_q;
                    end
                    // A pulse starting mid-divide is counted here so HIGH resumes without losing cycles.
                    if (rise) begin
                        held     <= 1'b1;
                        high_cnt <= 32'd1;
                    end else if (held && line) begin
                        high_cnt <= high_cnt + 32'd1;
                    end
                end
                default: ;
            endcase

            if (rise)
                to_cnt <= 32'd0;
            else if (to_cnt != TO_MAX)
                to_cnt <= to_cnt + 32'd1;

            if (to_cnt == TO_MAX)
                bus.signal_lost <= 1'b1;
            else if (div_done && !err_q)
                bus.signal_lost <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture with timing scaled by 1/100 (frame 2000, pulse range 250..1500 cycles).
module tb_pwm_capture;
    localparam int PMIN = 250;
    localparam int PMAX = 1500;
    localparam int AMAX = 130;
    // Two synchronizer cycles from the pwm_in drive edge, then the decode latency.
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int EXP_LAT = 2 + 34;
`else
    localparam int EXP_LAT = 2 + 26;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    pwm_capture_if bus_if();

    pwm_capture #(
        .CLK_FREQ (100_000),
        .PWM_FREQ (50),
        .PULSE_MIN(PMIN),
        .PULSE_MAX(PMAX),
        .ACCEL_MAX(AMAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pw;
        logic [15:0] d;
        logic        err;
        logic        lost;
        int          c;
    } rec_t;

    typedef struct {
        int   w;
        int   gap;
        int   d;
        logic err;
    } vec_t;

    rec_t recq[$];
    vec_t vt[11];
    int   cyc  = 0;
    int   nvec = 0;
    int   nmis = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (bus_if.data_valid === 1'b1)
            recq.push_back('{bus_if.pulse_width, bus_if.data_out, bus_if.range_err,
                             bus_if.signal_lost, cyc});

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        bus_if.pwm_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int ref_data(input int w);
        if (w <= PMIN) return 0;
        if (w >= PMAX) return AMAX;
        return ((w - PMIN) * AMAX) / (PMAX - PMIN);
    endfunction

    function automatic logic ref_err(input int w);
        return (w < PMIN) || (w > PMAX);
    endfunction

    task automatic expect_rec(input string nm, input int fall, input int w, input int d,
                              input logic err);
        rec_t r;
        for (int i = 0; i < 400 && recq.size() == 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (recq.size() == 0) begin
            nvec++;
            nmis++;
            $display("FAIL %s: no data_valid within 400 cycles", nm);
        end else begin
            r = recq.pop_front();
            chk({nm, " width"},       r.pw,           32'(w));
            chk({nm, " data"},        32'(r.d),       32'(d));
            chk({nm, " range_err"},   32'(r.err),     32'(err));
            chk({nm, " signal_lost"}, 32'(r.lost),    32'd0);
            chk({nm, " latency"},     32'(r.c - fall), 32'(EXP_LAT));
        end
    endtask

    initial begin
        int f;
        int f2;
        vt[0]  = '{750,  60, 52,  1'b0};
        vt[1]  = '{250,  60, 0,   1'b0};
        vt[2]  = '{1500, 60, 130, 1'b0};
        vt[3]  = '{200,  60, 0,   1'b1};
        vt[4]  = '{1600, 60, 130, 1'b1};
        vt[5]  = '{251,  60, 0,   1'b0};
        vt[6]  = '{1499, 60, 129, 1'b0};
        vt[7]  = '{260,  60, 1,   1'b0};
        vt[8]  = '{1000, 60, 78,  1'b0};
        vt[9]  = '{249,  60, 0,   1'b1};
        vt[10] = '{1501, 60, 130, 1'b1};

        bus_if.pwm_in = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset pulse_width", bus_if.pulse_width, 32'd0);
        chk("reset data_out",    32'(bus_if.data_out), 32'd0);
        chk("reset data_valid",  32'(bus_if.data_valid), 32'd0);
        chk("reset range_err",   32'(bus_if.range_err), 32'd0);
        chk("reset signal_lost", 32'(bus_if.signal_lost), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 20);

        for (int i = 0; i < 11; i++) begin
            drive(1'b1, vt[i].w);
            f = cyc;
            drive(1'b0, vt[i].gap);
            expect_rec($sformatf("vec%0d", i), f, vt[i].w, vt[i].d, vt[i].err);
        end

        // Second pulse rises while the first is still being divided.
        drive(1'b1, 750);
        f = cyc;
        drive(1'b0, 10);
        drive(1'b1, 1000);
        f2 = cyc;
        drive(1'b0, 60);
        expect_rec("held first", f, 750, 52, 1'b0);
        expect_rec("held second", f2, 1000, 78, 1'b0);

        // Pulse longer than a frame: aborted, outputs other than range_err keep their values.
        drive(1'b1, 2100);
        drive(1'b0, 60);
        chk("abort no valid",     32'(recq.size()), 32'd0);
        chk("abort range_err",    32'(bus_if.range_err), 32'd1);
        chk("abort data_out",     32'(bus_if.data_out), 32'd78);
        chk("abort pulse_width",  bus_if.pulse_width, 32'd1000);
        recq.delete();
        drive(1'b1, 750);
        f = cyc;
        drive(1'b0, 60);
        expect_rec("after abort", f, 750, 52, 1'b0);

        drive(1'b1, 400);
        rst = 1'b1;
        drive(1'b1, 3);
        chk("rst mid-pulse data_out", 32'(bus_if.data_out), 32'd0);
        rst = 1'b0;
        drive(1'b1, 347);
        drive(1'b0, 80);
        chk("rst mid-pulse no valid", 32'(recq.size()), 32'd0);
        recq.delete();

        drive(1'b1, 750);
        drive(1'b0, 10);
        rst = 1'b1;
        drive(1'b0, 2);
        rst = 1'b0;
        drive(1'b0, 80);
        chk("rst mid-divide no valid", 32'(recq.size()), 32'd0);
        recq.delete();
        drive(1'b1, 750);
        f = cyc;
        drive(1'b0, 60);
        expect_rec("after reset", f, 750, 52, 1'b0);

        drive(1'b0, 4100);
        chk("signal_lost set", 32'(bus_if.signal_lost), 32'd1);
        drive(1'b1, 750);
        f = cyc;
        chk("signal_lost held until valid", 32'(bus_if.signal_lost), 32'd1);
        drive(1'b0, 60);
        expect_rec("signal recovered", f, 750, 52, 1'b0);

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        drive(1'b1, 3);
        drive(1'b0, 60);
        chk("glitch filtered", 32'(recq.size()), 32'd0);
        recq.delete();
`else
        drive(1'b1, 3);
        f = cyc;
        drive(1'b0, 60);
        expect_rec("short pulse", f, 3, 0, 1'b1);
`endif

        for (int i = 0; i < 15; i++) begin
            int w;
            int g;
            w = int'($urandom_range(150, 1700));
            g = int'($urandom_range(40, 300));
            drive(1'b1, w);
            f = cyc;
            drive(1'b0, g);
            expect_rec($sformatf("rand%0d w=%0d", i, w), f, w, ref_data(w), ref_err(w));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter CLK_FREQ, 50_000_000, clock frequency in Hz.
REQ-002 Parameter PWM_FREQ, 50, expected servo frame rate in Hz; PWM_PERIOD = CLK_FREQ/PWM_FREQ.
REQ-003 Parameter PULSE_MIN, 25_000, pulse width in clk cycles that maps to data 0.
REQ-004 Parameter PULSE_MAX, 150_000, pulse width in clk cycles that maps to data ACCEL_MAX.
REQ-005 Parameter ACCEL_MAX, 130, full-scale decoded magnitude.
REQ-006 Port: clk, input, 1, sole clock; all logic on posedge.
REQ-007 Port: rst, input, 1, asynchronous active-high reset.
REQ-008 Port: pwm_in, input, 1, asynchronous servo PWM line.
REQ-009 Port: pulse_width, output, 32, last measured high time in clk cycles.
REQ-010 Port: data_out, output, signed 16, decoded magnitude, 0..ACCEL_MAX.
REQ-011 Port: data_valid, output, 1, one-cycle strobe when data_out and pulse_width update.
REQ-012 Port: range_err, output, 1, last pulse was outside PULSE_MIN..PULSE_MAX.
REQ-013 Port: signal_lost, output, 1, no rising edge seen within timeout.

Function
REQ-014 pwm_in SHALL pass through a 2-flop synchronizer; all edge detection SHALL use the synchronized signal only.
REQ-015 FSM states SHALL be WAIT_LOW, IDLE, HIGH, DIV.
- WAIT_LOW: entered from reset; go to IDLE on first synchronized low sample, so a partial pulse is never measured.
- IDLE: go to HIGH on rising edge; high counter loads 1.
- HIGH: counter increments each high cycle; on first low sample, latch count and go to DIV.
- DIV: compute the mapping, then go to IDLE.
REQ-016 Measured width SHALL equal the number of clk cycles the synchronized line was high; a 75_000-cycle input pulse SHALL yield pulse_width = 75_000.
REQ-017 If the high count reaches PWM_PERIOD, the FSM SHALL abort to WAIT_LOW, set range_err, and leave data_out unchanged without asserting data_valid.
REQ-018 Mapping: data_out = ((W - PULSE_MIN) * ACCEL_MAX) / (PULSE_MAX - PULSE_MIN), truncated, computed with an unsigned 24-iteration sequential restoring divider, one quotient bit per cycle.
REQ-019 Saturation: W < PULSE_MIN SHALL give data_out 0 with range_err=1; W > PULSE_MAX SHALL give data_out ACCEL_MAX with range_err=1; otherwise range_err=0.
REQ-020 pulse_width, data_out and range_err SHALL update together in the same cycle that data_valid is high; data_valid SHALL assert exactly 26 cycles after the first synchronized low sample.
REQ-021 A rising edge arriving during DIV SHALL be held; HIGH SHALL be entered immediately after DIV, with the count starting from the held edge cycle, so no cycles are lost.
REQ-022 Timeout counter SHALL clear on every rising edge; on reaching 2*PWM_PERIOD cycles, signal_lost SHALL assert and the counter SHALL saturate.
REQ-023 signal_lost SHALL deassert on the next data_valid with range_err=0.

Reset
REQ-024 While rst is high: FSM=WAIT_LOW, pulse_width=0, data_out=0, data_valid=0, range_err=0, signal_lost=0, and all counters and synchronizer flops are 0.
REQ-025 Reset asserted mid-pulse or mid-divide SHALL discard the measurement; no data_valid SHALL be generated for that pulse.

Configuration
REQ-026 Macro PWM_CAPTURE_GLITCH_FILTER_EN: when defined, the synchronized line SHALL feed a filter that changes state only after 8 consecutive equal samples. This adds 8 cycles to edge latency but not to measured width, and data_valid latency becomes 34 cycles. When undefined, no filter is present and timing is as REQ-020.

Verification
REQ-027 75_000-cycle high pulse in a 1_000_000-cycle frame -> pulse_width=75_000, data_out=52, range_err=0, data_valid 26 cycles after the fall.
REQ-028 25_000 and 150_000 cycle pulses -> data_out 0 and 130 respectively, range_err=0.
REQ-029 20_000 then 160_000 cycle pulses -> data_out 0 and 130 respectively, range_err=1 for each.
REQ-030 pwm_in held low for 2_000_000 cycles -> signal_lost=1; a following valid 75_000 pulse -> signal_lost=0 at its data_valid.
REQ-031 rst pulsed at cycle 40_000 of a 75_000 pulse -> no data_valid for that pulse; the next full pulse decodes correctly.
REQ-032 With PWM_CAPTURE_GLITCH_FILTER_EN: a 3-cycle high glitch -> no measurement; a 75_000 pulse -> data_out=52, with a 34-cycle latency.
